// File: rtl/cpc_bus_initiator.sv
// Z80-style CPC expansion-bus master: turns single commands into memory, I/O
// and opcode-fetch/refresh bus cycles, honouring READY wait states and timeouts.
module cpc_bus_initiator #(
  parameter int unsigned MAX_WAIT = 16,
  parameter logic [7:0]  I_REG    = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_type,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        MREQ_B,
  output logic        IOREQ_B,
  output logic        RD_B,
  output logic        WR_B,
  output logic        M1_B,
  output logic        RFSH_B,
  input  logic        READY
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_MRD = 3'd0, OP_MWR = 3'd1, OP_IORD = 3'd2, OP_IOWR = 3'd3, OP_FETCH = 3'd4
  } op_e;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  fetch_data_q, fetch_data_d;
  logic [7:0]  r_q, r_d;
  logic [7:0]  wait_q, wait_d;
  logic        ready_sample;

  logic [15:0] a_q, a_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  logic        mreq_b_q, mreq_b_d, ioreq_b_q, ioreq_b_d, rd_b_q, rd_b_d;
  logic        wr_b_q, wr_b_d, m1_b_q, m1_b_d, rfsh_b_q, rfsh_b_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;

  // Sequencing: which T-state comes next and what the response carries.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    fetch_data_d = fetch_data_q;
    r_d          = r_q;
    wait_d       = wait_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    ready_sample = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_type > 3'd4) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 8'h00;
          end else begin
            state_d = S_T1;
            op_d    = op_e'(cmd_type);
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            wait_d  = 8'h00;
          end
        end
      end
      S_T1: state_d = S_T2;
      S_T2: begin
        if (op_q == OP_IORD || op_q == OP_IOWR) state_d = S_TW;
        else ready_sample = 1'b1;
      end
      S_TW: ready_sample = 1'b1;
      S_T3: begin
        if (op_q == OP_FETCH) begin
          state_d = S_T4;
        end else begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (op_q == OP_MRD || op_q == OP_IORD) ? D_in : 8'h00;
        end
      end
      S_T4: begin
        state_d     = S_DONE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = fetch_data_q;
        r_d         = {r_q[7], r_q[6:0] + 7'd1};
      end
      default: state_d = S_IDLE;
    endcase

    // The auto-inserted I/O TW is a sample point too, but does not count as a wait.
    if (ready_sample) begin
      if (READY) begin
        state_d = S_T3;
        if (op_q == OP_FETCH) fetch_data_d = D_in;
      end else if (wait_q == WAIT_LIMIT) begin
        state_d     = S_DONE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = 8'h00;
      end else begin
        state_d = S_TW;
        wait_d  = wait_q + 8'd1;
      end
    end
  end

  // Bus pins are decoded from the state being entered so they are all registered.
  always_comb begin
    a_d         = a_q;
    d_out_d     = d_out_q;
    d_oe_d      = 1'b0;
    mreq_b_d    = 1'b1;
    ioreq_b_d   = 1'b1;
    rd_b_d      = 1'b1;
    wr_b_d      = 1'b1;
    m1_b_d      = 1'b1;
    rfsh_b_d    = 1'b1;
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_DONE);

    case (state_d)
      S_T1: begin
        a_d = addr_d;
        case (op_d)
          OP_MRD:   begin mreq_b_d = 1'b0; rd_b_d = 1'b0; end
          OP_MWR:   begin mreq_b_d = 1'b0; d_oe_d = 1'b1; d_out_d = wdata_d; end
          OP_IOWR:  begin d_oe_d = 1'b1; d_out_d = wdata_d; end
          OP_FETCH: begin m1_b_d = 1'b0; mreq_b_d = 1'b0; rd_b_d = 1'b0; end
          default:  ;
        endcase
      end
      S_T2, S_TW, S_T3: begin
        case (op_d)
          OP_MRD:  begin mreq_b_d = 1'b0; rd_b_d = 1'b0; end
          OP_MWR:  begin mreq_b_d = 1'b0; wr_b_d = 1'b0; d_oe_d = 1'b1; end
          OP_IORD: begin ioreq_b_d = 1'b0; rd_b_d = 1'b0; end
          OP_IOWR: begin ioreq_b_d = 1'b0; wr_b_d = 1'b0; d_oe_d = 1'b1; end
          OP_FETCH: begin
            if (state_d == S_T3) begin
              mreq_b_d = 1'b0;
              rfsh_b_d = 1'b0;
              a_d      = {I_REG, r_q};
            end else begin
              m1_b_d   = 1'b0;
              mreq_b_d = 1'b0;
              rd_b_d   = 1'b0;
            end
          end
          default: ;
        endcase
      end
      S_T4: begin
        rfsh_b_d = 1'b0;
        a_d      = {I_REG, r_q};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, and RESET is sampled on the clock edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      op_q         <= OP_MRD;
      addr_q       <= 16'h0000;
      wdata_q      <= 8'h00;
      fetch_data_q <= 8'h00;
      r_q          <= 8'h00;
      wait_q       <= 8'h00;
      a_q          <= 16'h0000;
      d_out_q      <= 8'h00;
      d_oe_q       <= 1'b0;
      mreq_b_q     <= 1'b1;
      ioreq_b_q    <= 1'b1;
      rd_b_q       <= 1'b1;
      wr_b_q       <= 1'b1;
      m1_b_q       <= 1'b1;
      rfsh_b_q     <= 1'b1;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      fetch_data_q <= fetch_data_d;
      r_q          <= r_d;
      wait_q       <= wait_d;
      a_q          <= a_d;
      d_out_q      <= d_out_d;
      d_oe_q       <= d_oe_d;
      mreq_b_q     <= mreq_b_d;
      ioreq_b_q    <= ioreq_b_d;
      rd_b_q       <= rd_b_d;
      wr_b_q       <= wr_b_d;
      m1_b_q       <= m1_b_d;
      rfsh_b_q     <= rfsh_b_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign A         = a_q;
  assign D_out     = d_out_q;
  assign D_oe      = d_oe_q;
  assign MREQ_B    = mreq_b_q;
  assign IOREQ_B   = ioreq_b_q;
  assign RD_B      = rd_b_q;
  assign WR_B      = wr_b_q;
  assign M1_B      = m1_b_q;
  assign RFSH_B    = rfsh_b_q;

endmodule

// File: doc/cpc_bus_initiator.md
Name: cpc_bus_initiator

Overview:
- Synchronous Z80-style bus master. Generates CPC expansion-bus cycles (memory read/write, I/O read/write, opcode fetch with refresh) from a simple command/response interface.
- Drives the same A/D/MREQ_B/IOREQ_B/RD_B/WR_B/M1_B/RFSH_B signals that the 512K expansion CPLD decodes, and honours READY wait states.
- Used as the initiating end for bench and in-system exercise of the RAM expansion, e.g. bank-select writes to 0x7Fxx followed by banked reads and writes.

Parameters:
- MAX_WAIT, 16, maximum READY-induced wait states before the cycle is aborted (range 1..255).
- I_REG, 8'h00, upper byte of the refresh address.

Ports:
- CLK  in  1  system clock; one CLK period = one T-state.
- RESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_type  in  3  0=mem rd, 1=mem wr, 2=io rd, 3=io wr, 4=opcode fetch; 5..7 reserved.
- cmd_addr  in  16  bus address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  single-cycle completion pulse.
- rsp_rdata  out  8  captured read data; 0x00 for writes and aborts.
- rsp_err  out  1  qualifies rsp_valid; set on timeout or reserved cmd_type.
- A  out  16  address bus.
- D_out  out  8  data to bus.
- D_oe  out  1  data bus drive enable.
- D_in  in  8  data from bus.
- MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B  out  1 each  active-low strobes.
- READY  in  1  high = proceed; low = insert wait state.

Behaviour:
- Reset state:
  - state IDLE; all strobes 1; A=0x0000; D_out=0x00; D_oe=0.
  - rsp_valid=0; rsp_rdata=0x00; rsp_err=0; R register=0x00; wait counter=0.
  - cmd_ready=0 while RESET is high, 1 in IDLE afterwards.
- All outputs are registered. The command is latched on acceptance; the next cycle is T1.
- cmd_ready is high only in IDLE. The IDLE cycle that carries rsp_valid may also accept the next command, so back-to-back cycles have no gap beyond that IDLE cycle.
- Reserved cmd_type: accepted, no bus activity; the next cycle gives rsp_valid=1, rsp_err=1.
- States: IDLE, T1, T2, TW, T3, T4, DONE. DONE is the IDLE cycle carrying rsp_valid.
- Memory read:
  - T1: A=addr, MREQ_B=0, RD_B=0.
  - T2: strobes held.
  - T3: strobes held; D_in captured on the edge leaving T3.
  - Then all strobes return to 1.
- Memory write:
  - T1: A=addr, D_out=wdata, D_oe=1, MREQ_B=0.
  - T2 and T3: WR_B=0.
  - Strobes and D_oe return to 0/inactive after T3.
- I/O read/write:
  - T1: address (plus D_out/D_oe for writes).
  - T2, TW, T3: IOREQ_B=0 and RD_B or WR_B=0.
  - One automatic TW is always inserted. Read data is captured leaving T3.
- Opcode fetch:
  - T1, T2: M1_B=0, MREQ_B=0, RD_B=0. D_in captured on the edge leaving the last of T2/TW.
  - T3, T4: M1_B=1, RD_B=1, RFSH_B=0, A={I_REG, R}. MREQ_B=0 in T3 and 1 in T4.
  - R[6:0] increments by 1 on leaving T4 and wraps 0x7F->0x00. R[7] is unchanged.
- READY sampling:
  - Sampled on the edge leaving T2 (memory/fetch) or leaving each TW (I/O, including the automatic TW).
  - READY=0 at that edge: enter/stay in TW with strobes held, and increment the wait counter.
  - READY=1: go to T3.
- Timeout:
  - When the wait counter equals MAX_WAIT and READY is still 0, the cycle aborts.
  - Next cycle: all strobes=1, D_oe=0, DONE with rsp_err=1, rsp_rdata=0x00. R is not incremented.
  - The wait counter clears in T1.
- Nominal lengths, T1 to last T-state: memory read/write 3 clocks; I/O 4 clocks; fetch 4 clocks; plus READY waits.
- rsp_valid follows the last T-state by one clock.
- RESET mid-cycle: on the next edge every output takes its reset value. No response is issued for the interrupted command.

Test Plan:
- Memory read 0x4000, READY=1, D_in=0xA5: MREQ_B/RD_B low for exactly 3 clocks, A=0x4000; rsp_valid 1 clock later with rsp_rdata=0xA5, rsp_err=0.
- I/O write 0x7FC4, data 0xC4: A=0x7FC4; D_oe high and D_out=0xC4 for 4 clocks; IOREQ_B/WR_B low for 3 clocks (T2, auto TW, T3); MREQ_B stays 1.
- Memory read with READY held low 2 clocks from T2: 2 TWs inserted; strobes low for 5 clocks; data captured leaving T3.
- 130 consecutive fetches, I_REG=0x3F, R reset 0x00: M1_B low 2 clocks per fetch; RFSH_B low 2 clocks; refresh A runs 0x3F00..0x3F7F, then wraps to 0x3F00 with R[7]=0.
- MAX_WAIT=4, READY stuck low on an I/O read: strobes deassert after the timeout; rsp_valid with rsp_err=1, rsp_rdata=0x00; the next command is accepted in that same DONE cycle.
- RESET asserted during TW of a memory write: next edge all strobes=1, D_oe=0, no rsp_valid; cmd_ready returns 1 the cycle after RESET drops.
